// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: filters external and software reset requests, holds all
// domains in reset, then releases them one at a time in index order.
// rst_cause keeps sticky reset-cause bits for firmware to read back.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int NUM_SRC     = 2,
    parameter int SYNC_DEPTH  = 2,
    parameter int MIN_PULSE   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     ext_rst_req,
    input  logic                   sw_rst_req,
    input  logic                   cause_clr,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   seq_done,
    output logic [NUM_SRC+1:0]     rst_cause
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAX_ALL = (MAX_HS > MIN_PULSE) ? MAX_HS : MIN_PULSE;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int FW      = $clog2(MIN_PULSE + 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t                              state;
    logic   [CW-1:0]                     cnt;
    logic   [IW-1:0]                     idx;
    logic   [NUM_SRC-1:0][SYNC_DEPTH-1:0] sync;
    logic   [NUM_SRC-1:0][FW-1:0]         filt;
    logic   [NUM_SRC-1:0]                s;
    logic   [NUM_SRC-1:0]                v;
    logic                                sw_q;
    logic                                trigger;

    // Synchronised request level and filter-qualified request per source
    always_comb begin
        s = '0;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s[i] = sync[i][SYNC_DEPTH-1];
            v[i] = (filt[i] == FW'(MIN_PULSE));
        end
    end

    assign trigger     = (|v) | sw_q;
    assign domain_rstn = ~domain_rst;

    // Synchroniser chains for the asynchronous external requests
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                sync[i] <= {sync[i][SYNC_DEPTH-2:0], ext_rst_req[i]};
        end
    end

    // Glitch filter: request must stay high MIN_PULSE cycles; counter saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!s[i])
                    filt[i] <= '0;
                else if (filt[i] != FW'(MIN_PULSE))
                    filt[i] <= filt[i] + FW'(1);
            end
        end
    end

    // Software request is registered once before it can trigger
    always_ff @(posedge clk) begin
        if (reset) sw_q <= 1'b0;
        else       sw_q <= sw_rst_req;
    end

    // Sticky cause bits; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset)
            rst_cause <= (NUM_SRC+2)'(1);
        else
            rst_cause <= (cause_clr ? '0 : rst_cause) | {v, sw_q, 1'b0};
    end

    // Sequencer: hold until quiet for HOLD_CYCLES, then release domains in order
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HOLD;
            cnt        <= '0;
            idx        <= '0;
            domain_rst <= '1;
            seq_done   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    domain_rst <= '1;
                    seq_done   <= 1'b0;
                    if (trigger) begin
                        cnt <= '0;
                    end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state      <= RELEASE;
                        idx        <= '0;
                        cnt        <= '0;
                        domain_rst <= ~NUM_DOMAINS'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (trigger) begin
                        state      <= HOLD;
                        domain_rst <= '1;
                        cnt        <= '0;
                    end else if (cnt == CW'(STAGE_DELAY - 1)) begin
                        if (idx == IW'(NUM_DOMAINS - 1)) begin
                            state    <= RUN;
                            seq_done <= 1'b1;
                        end else begin
                            idx        <= idx + IW'(1);
                            // 2 << idx selects bit idx+1, the next domain to release
                            domain_rst <= domain_rst & ~(NUM_DOMAINS'(2) << idx);
                            cnt        <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (trigger) begin
                        state      <= HOLD;
                        domain_rst <= '1;
                        seq_done   <= 1'b0;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state      <= HOLD;
                    domain_rst <= '1;
                    seq_done   <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl at default parameters.
// ec counts edges since reset was last released; checks happen 1ns after an edge.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ext_rst_req;
    logic       sw_rst_req;
    logic       cause_clr;
    logic [3:0] domain_rst;
    logic [3:0] domain_rstn;
    logic       seq_done;
    logic [3:0] rst_cause;

    int vectors     = 0;
    int miscompares = 0;
    int ec          = 0;

    rst_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ext_rst_req (ext_rst_req),
        .sw_rst_req  (sw_rst_req),
        .cause_clr   (cause_clr),
        .domain_rst  (domain_rst),
        .domain_rstn (domain_rstn),
        .seq_done    (seq_done),
        .rst_cause   (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic run_to(input int t);
        while (ec < t) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        ec    = 0;
    endtask

    initial begin
        reset       = 1'b1;
        ext_rst_req = '0;
        sw_rst_req  = 1'b0;
        cause_clr   = 1'b0;

        // 1: power-on sequence
        do_reset(3);
        chk("rst_domain",   domain_rst,  4'b1111);
        chk("rst_rstn",     domain_rstn, 4'b0000);
        chk("rst_done",     seq_done,    1'b0);
        chk("rst_cause",    rst_cause,   4'b0001);
        run_to(15); chk("s1_e15", domain_rst, 4'b1111);
        run_to(16); chk("s1_e16", domain_rst, 4'b1110);
        run_to(23); chk("s1_e23", domain_rst, 4'b1110);
        run_to(24); chk("s1_e24", domain_rst, 4'b1100);
        run_to(32); chk("s1_e32", domain_rst, 4'b1000);
        run_to(40); chk("s1_e40", domain_rst, 4'b0000);
        chk("s1_rstn40", domain_rstn, 4'b1111);
        run_to(47); chk("s1_done47", seq_done, 1'b0);
        run_to(48); chk("s1_done48", seq_done, 1'b1);
        chk("s1_cause", rst_cause, 4'b0001);

        // 2: software pulse in RUN
        run_to(50);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("s2_e51", domain_rst, 4'b0000);
        run_to(52);
        chk("s2_e52",    domain_rst, 4'b1111);
        chk("s2_done52", seq_done,   1'b0);
        chk("s2_cause",  rst_cause,  4'b0011);
        run_to(67);  chk("s2_e67", domain_rst, 4'b1111);
        run_to(68);  chk("s2_e68", domain_rst, 4'b1110);
        run_to(92);  chk("s2_e92", domain_rst, 4'b0000);
        run_to(99);  chk("s2_done99", seq_done, 1'b0);
        run_to(100); chk("s2_done100", seq_done, 1'b1);

        // 3: short external pulse ignored, long one accepted
        run_to(101);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        chk("s3_clr", rst_cause, 4'b0000);
        ext_rst_req[0] = 1'b1;
        run_to(105);
        ext_rst_req[0] = 1'b0;
        run_to(115);
        chk("s3_short_dom",   domain_rst, 4'b0000);
        chk("s3_short_done",  seq_done,   1'b1);
        chk("s3_short_cause", rst_cause,  4'b0000);
        ext_rst_req[0] = 1'b1;
        run_to(121);
        ext_rst_req[0] = 1'b0;
        chk("s3_e121", domain_rst, 4'b0000);
        run_to(122);
        chk("s3_e122",   domain_rst, 4'b1111);
        chk("s3_cause",  rst_cause,  4'b0100);

        // 4: long external request during HOLD keeps everything in reset
        run_to(125);
        ext_rst_req[1] = 1'b1;
        run_to(165);
        ext_rst_req[1] = 1'b0;
        chk("s4_e165", domain_rst, 4'b1111);
        run_to(183); chk("s4_e183", domain_rst, 4'b1111);
        run_to(184); chk("s4_e184", domain_rst, 4'b1110);
        chk("s4_cause", rst_cause, 4'b1100);
        run_to(216); chk("s4_done", seq_done, 1'b1);

        // 5: software trigger mid-RELEASE, then clear colliding with a set
        do_reset(2);
        run_to(24); chk("s5_e24", domain_rst, 4'b1100);
        run_to(28);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("s5_e29", domain_rst, 4'b1100);
        run_to(30);
        chk("s5_e30",    domain_rst, 4'b1111);
        chk("s5_cause",  rst_cause,  4'b0011);
        run_to(34);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        cause_clr  = 1'b1;
        tick();
        cause_clr  = 1'b0;
        chk("s5_clr_set", rst_cause, 4'b0010);
        run_to(51); chk("s5_e51", domain_rst, 4'b1111);
        run_to(52); chk("s5_e52", domain_rst, 4'b1110);

        // 6: reset asserted mid-RELEASE
        do_reset(2);
        run_to(2);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        chk("s6_clr", rst_cause, 4'b0000);
        run_to(32); chk("s6_e32", domain_rst, 4'b1000);
        run_to(35);
        reset = 1'b1;
        tick();
        chk("s6_dom",   domain_rst, 4'b1111);
        chk("s6_done",  seq_done,   1'b0);
        chk("s6_cause", rst_cause,  4'b0001);
        reset = 1'b0;
        ec    = 0;
        run_to(15); chk("s6_e15", domain_rst, 4'b1111);
        run_to(16); chk("s6_e16", domain_rst, 4'b1110);
        run_to(40); chk("s6_e40", domain_rst, 4'b0000);
        run_to(47); chk("s6_done47", seq_done, 1'b0);
        run_to(48); chk("s6_done48", seq_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
